maxpool2x2_fp32: RTL and testbench
==================================

# maxpool2x2_fp32

Single-channel 2×2, stride-2 max-pooling stage for the YOLOv3-Tiny pipeline. It consumes the raster-ordered FP32 pixel stream produced by one layer featuremap block, e.g. layer 4 at 104×104. It emits the down-sampled map, e.g. 52×52, as a raster-ordered FP32 stream for the next layer. One instance is placed per output featuremap.

## Interface
Parameters:
- DATA_WIDTH, 32, pixel width (IEEE-754 single precision); only 32 is supported.
- IMG_SIZE, 104, input map width and height in pixels.

Ports:
- Clk  in  1  single clock; all state updates on the rising edge.
- Rst  in  1  asynchronous, active-low reset. Rst=0 clears state immediately, independent of Clk.
- data_in  in  DATA_WIDTH  input pixel, valid when valid_in=1.
- valid_in  in  1  one pixel per cycle while high; gaps allowed.
- data_out  out  DATA_WIDTH  pooled pixel.
- valid_out  out  1  one-cycle pulse per pooled pixel.

## Operation
- Input is raster order: row 0 col 0 … col IMG_SIZE-1, then row 1, and so on.
- Counters col and row run 0..IMG_SIZE-1 and advance only on valid_in=1.
  - col wraps to 0 after IMG_SIZE-1 and increments row.
  - row wraps to 0 after IMG_SIZE-1, so back-to-back frames need no gap or control.
- FP max uses key(x) = sign ? ~x : x ^ 32'h80000000, compared unsigned.
  - Result is the operand with the larger key, as raw bits.
  - Gives +0 > -0, and total order over ±inf.
  - NaNs are not special-cased: positive NaN > +inf, negative NaN < -inf.
- Even row, even col: data_in captured into hold register.
- Even row, odd col: max(hold, data_in) written to line buffer entry col>>1.
  - Line buffer is IMG_SIZE/2 entries × 32 bits, synchronous-read friendly.
- Odd row, even col: data_in captured into hold; line buffer entry col>>1 read into register lb_q.
- Odd row, odd col: max(hold, data_in, lb_q) registered into data_out; valid_out=1 next cycle.
- Odd IMG_SIZE: last column and last row are discarded (floor behaviour). Counters still span IMG_SIZE.
- Output count per frame: (IMG_SIZE/2)², in raster order of the pooled map.
- Reset values:
  - data_out=0, valid_out=0.
  - col=0, row=0, hold=0, lb_q=0.
  - Line buffer is not reset; every entry is written before it is read.
- Reset mid-frame: partial frame discarded; next accepted pixel is treated as (0,0).

## Timing
- Throughput: one input pixel per cycle sustained; no backpressure, so the consumer must always accept.
- Latency: valid_out rises exactly 1 cycle after the clock edge accepting the bottom-right pixel (odd row, odd col) of each 2×2 window.
- valid_out is high for exactly one cycle per window, even when valid_in stays high.
- data_out holds its last value between pulses.
- Input gaps of any length, including between the two rows of a window, do not change results.
- Line buffer read (odd/even) precedes its use (odd/odd) by at least one cycle.
- Write (even/odd) and read of the same entry never happen in the same cycle.
- Last pixel of frame N and first pixel of frame N+1 on consecutive cycles:
  - frame N's last output is produced;
  - frame N+1 starts cleanly with col=0, row=0.

## Test plan
- IMG_SIZE=4, continuous input 1.0…16.0 raster. Required: 4 pulses with data 0x40C00000 (6.0), 0x41000000 (8.0), 0x41600000 (14.0), 0x41800000 (16.0), each 1 cycle after pixels 6, 8, 14, 16.
- IMG_SIZE=4, negatives/zero.
  - Block {-1.0, -2.0, -0.5, -3.0} -> 0xBF000000.
  - Block {-0.0, -1.0, -2.0, +0.0} -> 0x00000000.
  - Block {+inf, 1.0, -inf, 0.0} -> 0x7F800000.
- Random valid_in bubbles (0–5 idle cycles) on the ramp frame -> identical data sequence to the first test; 4 pulses total; each pulse 1 cycle after the accepting edge.
- Two ramp frames back-to-back with no gap (second frame offset +16.0) -> 8 pulses: 6, 8, 14, 16, then 22, 24, 30, 32 (0x41B00000, 0x41C00000, 0x41F00000, 0x42000000).
- Rst asserted low for 2 cycles after 6 pixels of a frame (asynchronously, mid-cycle) -> data_out=0 and valid_out=0 immediately; a following full ramp frame yields exactly the 4 values of the first test.
- IMG_SIZE=104, random finite FP32 frame -> exactly 2704 pulses, all matching the reference model bit-exactly; IMG_SIZE=5 run yields 4 pulses that ignore col 4 and row 4.

Source files
------------

// File: rtl/maxpool2x2_fp32.sv
// Single-channel 2x2 / stride-2 FP32 max-pooling stage for a raster-ordered pixel stream.
// Even rows are pair-reduced into a half-width line buffer; odd rows complete each window.
module maxpool2x2_fp32 #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_SIZE   = 104
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out
);

  localparam int HALF = IMG_SIZE / 2;
  localparam int CW   = $clog2(IMG_SIZE);
  localparam int AW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(IMG_SIZE - 1);
  localparam bit  ODD  = (IMG_SIZE % 2) == 1;

  // Sign-magnitude floats become monotonic unsigned keys: negatives flipped, positives lifted.
  function automatic logic [DATA_WIDTH-1:0] fp_key(input logic [DATA_WIDTH-1:0] x);
    return x[DATA_WIDTH-1] ? ~x : (x ^ {1'b1, {(DATA_WIDTH-1){1'b0}}});
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fp_max(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    return (fp_key(a) >= fp_key(b)) ? a : b;
  endfunction

  logic [CW-1:0]         r_col;
  logic [CW-1:0]         r_row;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] r_lb_q;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid_out;
  logic [DATA_WIDTH-1:0] r_lb [HALF];

  logic                  w_in_win;
  logic                  w_accept;
  logic                  w_lb_we;
  logic [AW-1:0]         w_lb_addr;
  logic [DATA_WIDTH-1:0] w_pair_max;
  logic [DATA_WIDTH-1:0] w_win_max;

  // With an odd map size the trailing column and row belong to no window.
  assign w_in_win   = !(ODD && ((r_col == LAST) || (r_row == LAST)));
  assign w_accept   = valid_in && w_in_win;
  assign w_lb_we    = w_accept && !r_row[0] && r_col[0];
  assign w_lb_addr  = r_col[AW:1];
  assign w_pair_max = fp_max(r_hold, data_in);
  assign w_win_max  = fp_max(w_pair_max, r_lb_q);

  // NOTE: state registers use non-blocking assignments so every update samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_hold      <= '0;
      r_lb_q      <= '0;
      r_data_out  <= '0;
      r_valid_out <= 1'b0;
    end else begin
      r_valid_out <= 1'b0;
      if (valid_in) begin
        if (r_col == LAST) begin
          r_col <= '0;
          r_row <= (r_row == LAST) ? '0 : r_row + CW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end
      if (w_accept) begin
        unique case ({r_row[0], r_col[0]})
          2'b00: r_hold <= data_in;
          2'b01: ;
          2'b10: begin
            r_hold <= data_in;
            r_lb_q <= r_lb[w_lb_addr];
          end
          2'b11: begin
            r_data_out  <= w_win_max;
            r_valid_out <= 1'b1;
          end
        endcase
      end
    end
  end

  // NOTE: the line buffer has no reset; every entry is written on an even row before its odd-row read.
  always_ff @(posedge Clk) begin
    if (w_lb_we) r_lb[w_lb_addr] <= w_pair_max;
  end

  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;

endmodule

// File: tb/tb_maxpool2x2_fp32.sv
// Directed bench for maxpool2x2_fp32: three map sizes (4, 104, 5) share one clock and reset.
// A window-level reference model plus hand-computed sequences check data, timing and reset.
module tb_maxpool2x2_fp32;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic [31:0] data = '0;
  logic        valid = 1'b0;
  int          sel = 0;
  int          isz = 4;

  logic        vin0, vin1, vin2;
  logic [31:0] dout0, dout1, dout2;
  logic        vout0, vout1, vout2;
  logic [31:0] cur_d;
  logic        cur_v;

  int          checks = 0;
  int          errors = 0;

  logic [31:0] pix [104][104];
  int          m_row = 0;
  int          m_col = 0;
  logic [31:0] last_d [3];
  logic [31:0] obs [$];
  logic [31:0] expq [$];

  always #5 Clk = ~Clk;

  assign vin0  = valid && (sel == 0);
  assign vin1  = valid && (sel == 1);
  assign vin2  = valid && (sel == 2);
  assign cur_d = (sel == 0) ? dout0 : (sel == 1) ? dout1 : dout2;
  assign cur_v = (sel == 0) ? vout0 : (sel == 1) ? vout1 : vout2;

  maxpool2x2_fp32 #(.DATA_WIDTH(32), .IMG_SIZE(4)) u_dut4 (
    .Clk(Clk), .Rst(Rst), .data_in(data), .valid_in(vin0), .data_out(dout0), .valid_out(vout0));
  maxpool2x2_fp32 #(.DATA_WIDTH(32), .IMG_SIZE(104)) u_dut104 (
    .Clk(Clk), .Rst(Rst), .data_in(data), .valid_in(vin1), .data_out(dout1), .valid_out(vout1));
  maxpool2x2_fp32 #(.DATA_WIDTH(32), .IMG_SIZE(5)) u_dut5 (
    .Clk(Clk), .Rst(Rst), .data_in(data), .valid_in(vin2), .data_out(dout2), .valid_out(vout2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  // Reference max by sign/magnitude cases: positive beats negative, then magnitude decides.
  function automatic logic [31:0] ref_max(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return a[31] ? b : a;
    if (!a[31]) return (a[30:0] >= b[30:0]) ? a : b;
    return (a[30:0] <= b[30:0]) ? a : b;
  endfunction

  function automatic logic [31:0] int2fp(input int n);
    int e = 0;
    while ((n >> (e + 1)) != 0) e++;
    return {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
  endfunction

  function automatic logic [31:0] rand_fp();
    if ($urandom_range(0, 15) == 0) return {1'($urandom), 31'd0};
    return {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
  endfunction

  // One clock cycle: drive on the falling edge, check just after the rising edge.
  task automatic cyc(input logic v, input logic [31:0] d);
    logic        exp_v;
    logic [31:0] exp_d;
    int          lim;
    @(negedge Clk);
    valid = v;
    data  = d;
    exp_v = 1'b0;
    exp_d = '0;
    lim   = 2 * (isz / 2);
    if (v) begin
      pix[m_row][m_col] = d;
      if ((m_row % 2 == 1) && (m_col % 2 == 1) && (m_row < lim) && (m_col < lim)) begin
        exp_v = 1'b1;
        exp_d = ref_max(ref_max(pix[m_row-1][m_col-1], pix[m_row-1][m_col]),
                        ref_max(pix[m_row][m_col-1], d));
      end
      if (m_col == isz - 1) begin
        m_col = 0;
        m_row = (m_row == isz - 1) ? 0 : m_row + 1;
      end else begin
        m_col++;
      end
    end
    @(posedge Clk);
    #1;
    check("valid_out", {31'd0, cur_v}, {31'd0, exp_v});
    if (exp_v) begin
      check("data_out", cur_d, exp_d);
      last_d[sel] = exp_d;
    end else begin
      check("data_hold", cur_d, last_d[sel]);
    end
    if (cur_v) obs.push_back(cur_d);
  endtask

  task automatic compare_seq(input string tag);
    check({tag, "_count"}, 32'(obs.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++)
      check(tag, (i < obs.size()) ? obs[i] : 32'hxxxxxxxx, expq[i]);
    obs.delete();
  endtask

  task automatic model_reset();
    m_row = 0;
    m_col = 0;
    for (int i = 0; i < 3; i++) last_d[i] = '0;
  endtask

  initial begin
    logic [31:0] neg_frame [16];
    neg_frame = '{32'hBF800000, 32'hC0000000, 32'h80000000, 32'hBF800000,
                  32'hBF000000, 32'hC0400000, 32'hC0000000, 32'h00000000,
                  32'h7F800000, 32'h3F800000, 32'h40000000, 32'h40000000,
                  32'hFF800000, 32'h00000000, 32'h40000000, 32'h40000000};
    model_reset();
    repeat (3) @(negedge Clk);
    check("rst_data4", dout0, 32'h0);
    check("rst_valid4", {31'd0, vout0}, 32'h0);
    check("rst_data104", dout1, 32'h0);
    check("rst_valid5", {31'd0, vout2}, 32'h0);
    Rst = 1'b1;

    // Continuous ramp 1.0..16.0.
    for (int i = 1; i <= 16; i++) cyc(1'b1, int2fp(i));
    expq = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
    compare_seq("ramp");

    // Negatives, signed zeros and infinities.
    for (int i = 0; i < 16; i++) cyc(1'b1, neg_frame[i]);
    expq = '{32'hBF000000, 32'h00000000, 32'h7F800000, 32'h40000000};
    compare_seq("neg");

    // Ramp with random idle gaps.
    for (int i = 1; i <= 16; i++) begin
      repeat ($urandom_range(0, 5)) cyc(1'b0, $urandom);
      cyc(1'b1, int2fp(i));
    end
    cyc(1'b0, '0);
    expq = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
    compare_seq("bubble");

    // Two frames back to back, the second offset by 16.0.
    for (int i = 1; i <= 32; i++) cyc(1'b1, int2fp(i));
    expq = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000,
             32'h41B00000, 32'h41C00000, 32'h41F00000, 32'h42000000};
    compare_seq("b2b");

    // Asynchronous reset mid-frame, right after the first window's pulse.
    for (int i = 1; i <= 6; i++) cyc(1'b1, int2fp(i));
    #2;
    valid = 1'b0;
    Rst = 1'b0;
    #1;
    check("midrst_data", dout0, 32'h0);
    check("midrst_valid", {31'd0, vout0}, 32'h0);
    model_reset();
    obs.delete();
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
    for (int i = 1; i <= 16; i++) cyc(1'b1, int2fp(i));
    cyc(1'b0, '0);
    expq = '{32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000};
    compare_seq("postrst");

    // Full 104x104 random finite frame against the reference model.
    sel = 1;
    isz = 104;
    model_reset();
    for (int i = 0; i < 104 * 104; i++) cyc(1'b1, rand_fp());
    cyc(1'b0, '0);
    check("frame104_count", 32'(obs.size()), 32'd2704);
    obs.delete();

    // Odd map size: last column and row are dropped.
    sel = 2;
    isz = 5;
    model_reset();
    for (int i = 1; i <= 25; i++) cyc(1'b1, int2fp(i));
    cyc(1'b0, '0);
    expq = '{32'h40E00000, 32'h41100000, 32'h41880000, 32'h41980000};
    compare_seq("odd5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
